// File: rtl/serv_rf_ram_arb.sv
// serv_rf_ram_arb: arbitrates the SERV register-file RAM between the core (strict priority) and a
// debug port moving whole 32-bit registers in 32/WIDTH beats. Define SERV_RF_ARB_WDOG_EN for a stall watchdog.
module serv_rf_ram_arb #(
  parameter int WIDTH    = 2,
  parameter int CSR_REGS = 4,
  parameter int L2D      = $clog2((32 + CSR_REGS) * 32 / WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [L2D-1:0]   i_core_waddr,
  input  logic [WIDTH-1:0] i_core_wdata,
  input  logic             i_core_wen,
  input  logic [L2D-1:0]   i_core_raddr,
  input  logic             i_core_ren,
  output logic [WIDTH-1:0] o_core_rdata,
  output logic [L2D-1:0]   o_ram_waddr,
  output logic [WIDTH-1:0] o_ram_wdata,
  output logic             o_ram_wen,
  output logic [L2D-1:0]   o_ram_raddr,
  output logic             o_ram_ren,
  input  logic [WIDTH-1:0] i_ram_rdata,
  input  logic             i_dbg_req,
  input  logic             i_dbg_we,
  input  logic [5:0]       i_dbg_reg,
  input  logic [31:0]      i_dbg_wdat,
  output logic             o_dbg_ack,
  output logic [31:0]      o_dbg_rdat,
  output logic             o_dbg_err
);

  localparam int N     = 32 / WIDTH;
  localparam int CW    = $clog2(N + 1);
  localparam int NREGS = 32 + CSR_REGS;

  typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_e;

  state_e         state_q, state_d;
  logic [5:0]     dreg_q, dreg_d;
  logic [31:0]    shreg_q, shreg_d;
  logic [31:0]    rdat_q, rdat_d;
  logic [CW-1:0]  wbeat_q, wbeat_d, rbeat_q, rbeat_d, cbeat_q, cbeat_d;
  logic           rpend_q, rpend_d;
  logic           err_q, err_d;
  logic           dbg_wen, dbg_ren, timeout;
  logic [L2D-1:0] dbg_waddr, dbg_raddr;

  // Beat b of register r lives at r*N + b, so a word is stored LSB-first.
  assign dbg_waddr = L2D'(int'(dreg_q) * N + int'(wbeat_q));
  assign dbg_raddr = L2D'(int'(dreg_q) * N + int'(rbeat_q));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    dreg_d  = dreg_q;
    shreg_d = shreg_q;
    rdat_d  = rdat_q;
    wbeat_d = wbeat_q;
    rbeat_d = rbeat_q;
    cbeat_d = cbeat_q;
    rpend_d = rpend_q;
    err_d   = err_q;
    dbg_wen = 1'b0;
    dbg_ren = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_dbg_req) begin
          dreg_d  = i_dbg_reg;
          shreg_d = i_dbg_wdat;
          wbeat_d = '0;
          rbeat_d = '0;
          cbeat_d = '0;
          rpend_d = 1'b0;
          if (int'(i_dbg_reg) >= NREGS) begin
            err_d   = 1'b1;
            state_d = ACK;
          end else begin
            err_d   = 1'b0;
            state_d = i_dbg_we ? WR : RD;
          end
        end
      end
      WR: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = ACK;
        end else if (!i_core_wen) begin
          dbg_wen = 1'b1;
          shreg_d = shreg_q >> WIDTH;
          wbeat_d = wbeat_q + CW'(1);
          if (wbeat_q == CW'(N - 1)) state_d = ACK;
        end
      end
      RD: begin
        rpend_d = 1'b0;
        if (timeout) begin
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          if (!i_core_ren && rbeat_q < CW'(N)) begin
            dbg_ren = 1'b1;
            rbeat_d = rbeat_q + CW'(1);
            rpend_d = 1'b1;
          end
          // Read data arrives one cycle after a granted read, whatever the core does meanwhile.
          if (rpend_q) begin
            rdat_d[int'(cbeat_q) * WIDTH +: WIDTH] = i_ram_rdata;
            cbeat_d = cbeat_q + CW'(1);
            if (cbeat_q == CW'(N - 1)) state_d = ACK;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef SERV_RF_ARB_WDOG_EN
  logic [7:0] stall_q, stall_d;
  logic       beat_deny;

  assign beat_deny = (state_q == WR && i_core_wen) ||
                     (state_q == RD && i_core_ren && rbeat_q < CW'(N));
  assign timeout   = (state_q == WR || state_q == RD) && stall_q == 8'hFF;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE || dbg_wen || dbg_ren) stall_d = '0;
    else if (beat_deny)                         stall_d = stall_q + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!i_rst_n) begin
      state_q <= IDLE;
      dreg_q  <= '0;
      shreg_q <= '0;
      rdat_q  <= '0;
      wbeat_q <= '0;
      rbeat_q <= '0;
      cbeat_q <= '0;
      rpend_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dreg_q  <= dreg_d;
      shreg_q <= shreg_d;
      rdat_q  <= rdat_d;
      wbeat_q <= wbeat_d;
      rbeat_q <= rbeat_d;
      cbeat_q <= cbeat_d;
      rpend_q <= rpend_d;
      err_q   <= err_d;
    end
  end

  // Core always wins its port; its signals pass straight through with no added latency.
  assign o_ram_wen    = i_core_wen | dbg_wen;
  assign o_ram_waddr  = i_core_wen ? i_core_waddr : dbg_waddr;
  assign o_ram_wdata  = i_core_wen ? i_core_wdata : shreg_q[WIDTH-1:0];
  assign o_ram_ren    = i_core_ren | dbg_ren;
  assign o_ram_raddr  = i_core_ren ? i_core_raddr : dbg_raddr;
  assign o_core_rdata = i_ram_rdata;

  assign o_dbg_ack  = (state_q == ACK);
  assign o_dbg_err  = err_q;
  assign o_dbg_rdat = rdat_q;

endmodule
